// File: rtl/cpu_state_sequencer_if.sv
// Bundle between the CPU wrapper / control decoder and the state sequencer.
// master: drives opcode, func_code, waitrequest, alu_busy, pc_is_zero;
// slave: drives state, fetch_valid, active, retire, counters, bus_fault.
interface cpu_state_sequencer_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [5:0]             opcode;
    logic [5:0]             func_code;
    logic                   waitrequest;
    logic                   alu_busy;
    logic                   pc_is_zero;
    logic [2:0]             state;
    logic                   fetch_valid;
    logic                   active;
    logic                   retire;
    logic [COUNT_WIDTH-1:0] instr_count;
    logic [COUNT_WIDTH-1:0] stall_count;
    logic                   bus_fault;

    modport master (
        output opcode, func_code, waitrequest, alu_busy, pc_is_zero,
        input  state, fetch_valid, active, retire,
        input  instr_count, stall_count, bus_fault
    );

    modport slave (
        input  opcode, func_code, waitrequest, alu_busy, pc_is_zero,
        output state, fetch_valid, active, retire,
        output instr_count, stall_count, bus_fault
    );
endinterface

// File: rtl/cpu_state_sequencer.sv
// Multi-cycle MIPS phase sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITE_BACK,
// stalls, halt detection, retire/stall counters and waitrequest timeout.
// Ports: clk, reset_n (sync, active low), clk_enable, bus (slave modport).
module cpu_state_sequencer #(
    parameter int COUNT_WIDTH = 32,
    parameter int MAX_WAIT    = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_enable,
    cpu_state_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        FETCH_INSTR   = 3'b000,
        DECODE        = 3'b001,
        EXECUTE       = 3'b010,
        MEMORY_ACCESS = 3'b011,
        WRITE_BACK    = 3'b100,
        HALT          = 3'b101
    } state_t;

    localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

    state_t                 state_q;
    state_t                 next_state;
    logic [15:0]            wait_cnt;
    logic                   started;
    logic                   retire_q;
    logic                   fault_q;
    logic [COUNT_WIDTH-1:0] instr_q;
    logic [COUNT_WIDTH-1:0] stall_q;

    logic is_load;
    logic is_store;
    logic is_muldiv;
    logic halt_now;
    logic wait_stall;
    logic alu_stall;
    logic timeout;
    logic retiring;

    assign is_load   = bus.opcode inside {[6'h20:6'h26]};
    assign is_store  = bus.opcode inside {6'h28, 6'h29, 6'h2B};
    assign is_muldiv = (bus.opcode == 6'h00) &&
                       (bus.func_code inside {[6'h18:6'h1B]});

    // Halt is only armed once an instruction has retired, because the
    // PC legitimately sits at zero for the very first fetch.
    assign halt_now = bus.pc_is_zero && started;

    assign wait_stall = bus.waitrequest &&
        ((state_q == FETCH_INSTR && !halt_now) ||
         (state_q == MEMORY_ACCESS && (is_load || is_store)));
    assign alu_stall  = (state_q == EXECUTE) && is_muldiv && bus.alu_busy;
    assign timeout    = wait_stall && (wait_cnt >= MAX_W);

    always_comb begin
        next_state = state_q;
        retiring   = 1'b0;
        unique case (state_q)
            FETCH_INSTR: begin
                if (halt_now || timeout)
                    next_state = HALT;
                else if (!bus.waitrequest)
                    next_state = DECODE;
            end
            DECODE:
                next_state = EXECUTE;
            EXECUTE: begin
                if (!alu_stall)
                    next_state = MEMORY_ACCESS;
            end
            MEMORY_ACCESS: begin
                if (timeout) begin
                    next_state = HALT;
                end else if (!wait_stall) begin
                    if (is_load) begin
                        next_state = WRITE_BACK;
                    end else begin
                        next_state = FETCH_INSTR;
                        retiring   = 1'b1;
                    end
                end
            end
            WRITE_BACK: begin
                next_state = FETCH_INSTR;
                retiring   = 1'b1;
            end
            HALT:
                next_state = HALT;
            default:
                next_state = FETCH_INSTR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= FETCH_INSTR;
            wait_cnt <= '0;
            started  <= 1'b0;
            retire_q <= 1'b0;
            fault_q  <= 1'b0;
            instr_q  <= '0;
            stall_q  <= '0;
        end else if (clk_enable) begin
            state_q  <= next_state;
            retire_q <= retiring;
            if (retiring) begin
                instr_q <= instr_q + COUNT_WIDTH'(1);
                started <= 1'b1;
            end
            if ((wait_stall && !timeout) || alu_stall)
                stall_q <= stall_q + COUNT_WIDTH'(1);
            if (wait_stall && !timeout)
                wait_cnt <= wait_cnt + 16'd1;
            else
                wait_cnt <= '0;
            if (timeout)
                fault_q <= 1'b1;
        end
    end

    assign bus.state       = state_q;
    assign bus.fetch_valid = (state_q == FETCH_INSTR) && !halt_now;
    assign bus.active      = (state_q != HALT);
    assign bus.retire      = retire_q;
    assign bus.instr_count = instr_q;
    assign bus.stall_count = stall_q;
    assign bus.bus_fault   = fault_q;
endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Randomized scoreboard bench for cpu_state_sequencer.
// Instructions are expanded into expected per-cycle phase lists.
module tb_cpu_state_sequencer;
    localparam int CW = 8;
    localparam int MW = 4;

    localparam logic [2:0] S_F = 3'd0;
    localparam logic [2:0] S_D = 3'd1;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3;
    localparam logic [2:0] S_W = 3'd4;
    localparam logic [2:0] S_H = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       fv;
        logic       act;
        logic       ret;
        logic [7:0] ic;
        logic [7:0] sc;
        logic       bf;
    } exp_t;

    typedef struct packed {
        logic [2:0] st;
        logic       stall;
        logic       wr;
        logic       ab;
        logic       last;
        logic       pz1;
        logic       fault;
    } cyc_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_enable = 1'b1;

    cpu_state_sequencer_if #(.COUNT_WIDTH(CW)) bus ();

    cpu_state_sequencer #(.COUNT_WIDTH(CW), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    int m_instr;
    int m_stall;
    bit m_ret;
    bit m_started;
    bit m_fault;
    int freeze_n = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cyc_t mk(input logic [2:0] st,
                                input logic stall, wr, ab,
                                input logic last, pz1, fault);
        cyc_t c;
        c.st = st; c.stall = stall; c.wr = wr; c.ab = ab;
        c.last = last; c.pz1 = pz1; c.fault = fault;
        return c;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("state", int'(bus.state), int'(e.st));
            check("fetch_valid", int'(bus.fetch_valid), int'(e.fv));
            check("active", int'(bus.active), int'(e.act));
            check("retire", int'(bus.retire), int'(e.ret));
            check("instr_count", int'(bus.instr_count), int'(e.ic));
            check("stall_count", int'(bus.stall_count), int'(e.sc));
            check("bus_fault", int'(bus.bus_fault), int'(e.bf));
        end
    end

    task automatic do_reset(input logic en);
        clk_enable      = en;
        reset_n         = 1'b0;
        bus.waitrequest = rb();
        bus.alu_busy    = rb();
        bus.pc_is_zero  = rb();
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        clk_enable = 1'b1;
        m_instr = 0; m_stall = 0; m_ret = 0;
        m_started = 0; m_fault = 0;
    endtask

    task automatic run_cycle(input cyc_t c);
        logic pz;
        exp_t e;
        int   nfz;
        if (c.pz1)
            pz = 1'b1;
        else if (c.st == S_F)
            pz = m_started ? 1'b0 : rb();
        else
            pz = rb();
        e.st  = c.st;
        e.fv  = (c.st == S_F) && !(pz && m_started);
        e.act = (c.st != S_H);
        e.ret = m_ret;
        e.ic  = 8'(m_instr);
        e.sc  = 8'(m_stall);
        e.bf  = m_fault;
        nfz = freeze_n;
        freeze_n = 0;
        if (nfz == 0 && $urandom_range(0, 15) == 0)
            nfz = $urandom_range(1, 4);
        // Frozen cycles must show exactly what the live cycle will show.
        repeat (nfz) begin
            clk_enable      = 1'b0;
            bus.waitrequest = rb();
            bus.alu_busy    = rb();
            bus.pc_is_zero  = pz;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        clk_enable      = 1'b1;
        bus.waitrequest = c.wr;
        bus.alu_busy    = c.ab;
        bus.pc_is_zero  = pz;
        exp_q.push_back(e);
        m_ret = c.last;
        if (c.stall) m_stall++;
        if (c.last) begin
            m_instr++;
            m_started = 1;
        end
        if (c.fault) m_fault = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic halt_cycles(input int n);
        repeat (n) begin
            bus.opcode    = 6'($urandom);
            bus.func_code = 6'($urandom);
            run_cycle(mk(S_H, 0, rb(), rb(), 0, 0, 0));
        end
    endtask

    task automatic do_instr(input logic [5:0] op, fn,
                            input int nf, na, nm, abort_at);
        cyc_t q[$];
        bit ld, sto, md, flt;
        ld  = op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
        sto = op inside {6'h28, 6'h29, 6'h2B};
        md  = (op == 6'h00) && (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B});
        flt = 0;
        for (int i = 0; i < nf && i < MW; i++)
            q.push_back(mk(S_F, 1, 1, rb(), 0, 0, 0));
        if (nf > MW) begin
            q.push_back(mk(S_F, 0, 1, rb(), 0, 0, 1));
            flt = 1;
        end else begin
            q.push_back(mk(S_F, 0, 0, rb(), 0, 0, 0));
            q.push_back(mk(S_D, 0, rb(), rb(), 0, 0, 0));
            if (md) begin
                for (int i = 0; i < na; i++)
                    q.push_back(mk(S_E, 1, rb(), 1, 0, 0, 0));
                q.push_back(mk(S_E, 0, rb(), 0, 0, 0, 0));
            end else begin
                q.push_back(mk(S_E, 0, rb(), (na > 0) ? 1'b1 : rb(),
                               0, 0, 0));
            end
            if (ld || sto) begin
                for (int i = 0; i < nm && i < MW; i++)
                    q.push_back(mk(S_M, 1, 1, rb(), 0, 0, 0));
                if (nm > MW) begin
                    q.push_back(mk(S_M, 0, 1, rb(), 0, 0, 1));
                    flt = 1;
                end else begin
                    q.push_back(mk(S_M, 0, 0, rb(), !ld, 0, 0));
                    if (ld)
                        q.push_back(mk(S_W, 0, rb(), rb(), 1, 0, 0));
                end
            end else begin
                q.push_back(mk(S_M, 0, rb(), rb(), 1, 0, 0));
            end
        end
        bus.opcode    = op;
        bus.func_code = fn;
        for (int k = 0; k < q.size(); k++) begin
            if (k == abort_at) begin
                do_reset(rb());
                return;
            end
            run_cycle(q[k]);
        end
        if (flt) begin
            halt_cycles($urandom_range(3, 6));
            do_reset(rb());
        end
    endtask

    task automatic pc_halt();
        run_cycle(mk(S_F, 0, 1, rb(), 0, 1, 0));
        halt_cycles(6);
        do_reset(1'b1);
    endtask

    task automatic rand_instr(output logic [5:0] op, fn);
        logic [5:0] ops[10];
        logic [5:0] fns[10];
        int k;
        ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h20,
                6'h2B, 6'h28, 6'h3F, 6'h09};
        fns = '{6'h21, 6'h18, 6'h1B, 6'h1C, 6'h00, 6'h05,
                6'h00, 6'h11, 6'h18, 6'h18};
        k  = $urandom_range(0, 9);
        op = ops[k];
        fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[k];
        if (op == 6'h00 && fn != fns[k]) fn = fns[k];
    endtask

    initial begin
        logic [5:0] op, fn;
        bus.opcode      = 6'h00;
        bus.func_code   = 6'h00;
        bus.waitrequest = 1'b0;
        bus.alu_busy    = 1'b0;
        bus.pc_is_zero  = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b1);

        do_instr(6'h00, 6'h21, 0, 0, 0, -1);
        do_instr(6'h23, 6'h00, 0, 0, 3, -1);
        do_instr(6'h00, 6'h18, 0, 5, 0, -1);
        do_instr(6'h00, 6'h21, 0, 5, 0, -1);
        pc_halt();

        do_instr(6'h00, 6'h21, 2, 0, 0, -1);
        do_instr(6'h00, 6'h21, 0, 0, 0, -1);
        pc_halt();

        do_instr(6'h00, 6'h21, 10, 0, 0, -1);
        do_instr(6'h2B, 6'h00, 1, 0, 9, -1);

        do_instr(6'h00, 6'h21, 0, 0, 0, -1);
        freeze_n = 10;
        do_instr(6'h00, 6'h1A, 0, 3, 0, 3);
        do_instr(6'h23, 6'h00, 0, 0, 1, -1);
        freeze_n = 10;
        do_instr(6'h28, 6'h00, 0, 0, 2, -1);
        do_reset(1'b1);

        // Long run without reset so both 8-bit counters wrap.
        for (int i = 0; i < 300; i++) begin
            rand_instr(op, fn);
            do_instr(op, fn, $urandom_range(0, MW), $urandom_range(0, 4),
                     $urandom_range(0, MW), -1);
        end

        for (int i = 0; i < 40; i++) begin
            rand_instr(op, fn);
            case ($urandom_range(0, 3))
                0: do_instr(op, fn, $urandom_range(0, 2), 2, 1,
                            $urandom_range(0, 6));
                1: do_instr(op, fn, $urandom_range(0, MW + 2),
                            1, $urandom_range(0, MW + 2), -1);
                2: if (m_started) pc_halt();
                   else do_instr(op, fn, 0, 0, 0, -1);
                default: do_instr(op, fn, 1, 1, 1, -1);
            endcase
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
